corefifo_rd_ctrl_vdma: RTL and testbench

Read-side controller for the VDMA dual-clock FIFO, running entirely in the read clock domain. It synchronises the Gray-coded write pointer and converts it to binary with the existing Gray-to-binary converter. It maintains the binary/Gray read pointer, drives the FIFO RAM read port, and presents a first-word-fall-through (FWFT) output with valid/accept handshake plus occupancy flags.

---
 rtl/corefifo_rd_ctrl_vdma.sv | 147 ++++++++++++++
 tb/tb_corefifo_rd_ctrl_vdma.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/corefifo_rd_ctrl_vdma.sv
// Read-side controller for the VDMA dual-clock FIFO: write-pointer sync, read pointer, FWFT output stage.
// Optional sticky underflow detection is built only when CORE_VDMA_RDCTRL_UFLOW_EN is defined.

module corefifo_gray2bin #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_gray,
  output logic [N-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at and above it.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign o_bin[gi] = ^i_gray[N-1:gi];
  end

endmodule

module corefifo_rd_ctrl_vdma #(
  parameter int ADDRWIDTH     = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                 rclk,
  input  logic                 rreset,
  input  logic [ADDRWIDTH:0]   wptr_gray_in,
  output logic [ADDRWIDTH:0]   rptr_gray_out,
  output logic [ADDRWIDTH-1:0] ram_raddr,
  output logic                 ram_re,
  input  logic                 re,
  output logic                 dvld,
  output logic                 empty,
  output logic                 aempty,
  output logic [ADDRWIDTH:0]   rdcnt,
  output logic                 underflow
);

  // Handshake: a word is transferred at the rising edge where dvld=1 and re=1;
  // re while dvld=0 moves nothing.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  localparam logic [ADDRWIDTH:0] LP_PTR_ONE   = {{ADDRWIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRWIDTH:0] LP_AE_THRESH = AEMPTY_THRESH[ADDRWIDTH:0];

  logic [ADDRWIDTH:0] r_wsync1;
  logic [ADDRWIDTH:0] r_wsync2;
  logic [ADDRWIDTH:0] r_rptr_bin;
  logic [ADDRWIDTH:0] r_rptr_gray;
  logic [0:0]         r_state;

  logic [ADDRWIDTH:0] w_wptr_bin;
  logic [ADDRWIDTH:0] w_rptr_bin_nxt;
  logic [ADDRWIDTH:0] w_rptr_gray_nxt;
  logic [ADDRWIDTH:0] w_rdcnt;
  logic               w_ram_empty;
  logic               w_ram_re;
  logic               w_dvld;
  logic [0:0]         w_state_nxt;

  always_ff @(posedge rclk) begin
    if (rreset) begin
      r_wsync1 <= '0;
      r_wsync2 <= '0;
    end else begin
      r_wsync1 <= wptr_gray_in;
      r_wsync2 <= r_wsync1;
    end
  end

  corefifo_gray2bin #(
    .N (ADDRWIDTH + 1)
  ) u_wptr_g2b (
    .i_gray (r_wsync2),
    .o_bin  (w_wptr_bin)
  );

  // The extra MSB tells a full RAM apart from an empty one.
  assign w_ram_empty = (w_wptr_bin == r_rptr_bin);
  assign w_rdcnt     = w_wptr_bin - r_rptr_bin;
  assign w_dvld      = (r_state == ST_VALID);

  // Refill the output register when it is free or being drained this cycle.
  assign w_ram_re = !rreset && !w_ram_empty && (!w_dvld || re);

  assign w_rptr_bin_nxt  = r_rptr_bin + LP_PTR_ONE;
  assign w_rptr_gray_nxt = w_rptr_bin_nxt ^ (w_rptr_bin_nxt >> 1);

  always_ff @(posedge rclk) begin
    if (rreset) begin
      r_rptr_bin  <= '0;
      r_rptr_gray <= '0;
    end else if (w_ram_re) begin
      r_rptr_bin  <= w_rptr_bin_nxt;
      r_rptr_gray <= w_rptr_gray_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_ram_re) begin
          w_state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (re && !w_ram_re) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rreset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef CORE_VDMA_RDCTRL_UFLOW_EN
  logic r_underflow;

  // Sticky until reset: a consumer read against an empty output stage.
  always_ff @(posedge rclk) begin
    if (rreset) begin
      r_underflow <= 1'b0;
    end else if (re && !w_dvld) begin
      r_underflow <= 1'b1;
    end
  end

  assign underflow = r_underflow;
`else
  assign underflow = 1'b0;
`endif

  assign rptr_gray_out = r_rptr_gray;
  assign ram_raddr     = r_rptr_bin[ADDRWIDTH-1:0];
  assign ram_re        = w_ram_re;
  assign dvld          = w_dvld;
  assign empty         = !w_dvld;
  assign rdcnt         = w_rdcnt;
  assign aempty        = (w_rdcnt <= LP_AE_THRESH);

endmodule

// File: tb/tb_corefifo_rd_ctrl_vdma.sv
// Bench for corefifo_rd_ctrl_vdma: the bench plays writer and RAM, and checks against a count-based model.
module tb_corefifo_rd_ctrl_vdma;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int TH    = 1;

  logic          rclk = 1'b0;
  logic          rreset;
  logic          re;
  logic [AW:0]   wptr_gray_in;
  logic [AW:0]   rptr_gray_out;
  logic [AW-1:0] ram_raddr;
  logic          ram_re;
  logic          dvld;
  logic          empty;
  logic          aempty;
  logic [AW:0]   rdcnt;
  logic          underflow;

  always #5 rclk = ~rclk;

  corefifo_rd_ctrl_vdma #(
    .ADDRWIDTH     (AW),
    .AEMPTY_THRESH (TH)
  ) dut (
    .rclk          (rclk),
    .rreset        (rreset),
    .wptr_gray_in  (wptr_gray_in),
    .rptr_gray_out (rptr_gray_out),
    .ram_raddr     (ram_raddr),
    .ram_re        (ram_re),
    .re            (re),
    .dvld          (dvld),
    .empty         (empty),
    .aempty        (aempty),
    .rdcnt         (rdcnt),
    .underflow     (underflow)
  );

  // FIFO RAM with registered output, loaded by the DUT's read port.
  logic [7:0] mem [DEPTH];
  logic [7:0] ram_dout;
  always @(posedge rclk) begin
    if (ram_re) ram_dout <= mem[ram_raddr];
  end

  // Reference model: plain word counts, no modular pointers.
  int  m_wcount, m_ws1, m_ws2, m_fetched, m_consumed;
  bit  m_hold, m_uflow;
  logic [7:0] exp_q[$];
  int  n_cmp, n_fail;
  int  n_written;

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  function automatic bit has_room();
    return (m_wcount - m_consumed) < DEPTH;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit rv, input int nwr, input bit chk);
    int         rc;
    bit         exp_re;
    bit         exp_uf;
    logic [7:0] d;
    rreset = rst;
    re     = rv;
    if (rst) begin
      m_wcount   = 0;
      m_consumed = 0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < nwr; i++) begin
        d = 8'($urandom_range(0, 255));
        mem[m_wcount % DEPTH] = d;
        exp_q.push_back(d);
        m_wcount++;
      end
    end
    wptr_gray_in = gray(m_wcount);

    @(negedge rclk);
    rc     = m_ws2 - m_fetched;
    exp_re = !rst && (rc > 0) && (!m_hold || rv);
`ifdef CORE_VDMA_RDCTRL_UFLOW_EN
    exp_uf = m_uflow;
`else
    exp_uf = 1'b0;
`endif
    if (chk) begin
      check("ram_re",    32'(ram_re),        32'(exp_re));
      check("ram_raddr", 32'(ram_raddr),     32'(m_fetched % DEPTH));
      check("dvld",      32'(dvld),          32'(m_hold));
      check("empty",     32'(empty),         32'(!m_hold));
      check("rdcnt",     32'(rdcnt),         32'(rc));
      check("aempty",    32'(aempty),        32'(rc <= TH));
      check("rptr_gray", 32'(rptr_gray_out), 32'(gray(m_fetched)));
      check("underflow", 32'(underflow),     32'(exp_uf));
      if (!rst && m_hold && rv && exp_q.size() > 0) begin
        d = exp_q.pop_front();
        check("data", 32'(ram_dout), 32'(d));
        m_consumed++;
      end
    end

    @(posedge rclk);
    if (rst) begin
      m_ws1 = 0; m_ws2 = 0; m_fetched = 0; m_hold = 0; m_uflow = 0;
    end else begin
      if (rv && !m_hold) m_uflow = 1;
      if (exp_re) begin
        m_fetched++;
        m_hold = 1;
      end else if (rv && m_hold) begin
        m_hold = 0;
      end
      m_ws2 = m_ws1;
      m_ws1 = m_wcount;
    end
    #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_wcount = 0; m_ws1 = 0; m_ws2 = 0; m_fetched = 0; m_consumed = 0;
    m_hold = 0; m_uflow = 0;
    rreset = 1'b1; re = 1'b0; wptr_gray_in = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // reset state
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);

    // single word, no consumer
    cycle(0, 0, 1, 1);
    repeat (5) cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);

    // streaming a full RAM, consumer always ready (also reads past the end)
    cycle(0, 1, 8, 1);
    repeat (14) cycle(0, 1, 0, 1);

    // backpressure and pointer wrap: 20 words with re toggling
    n_written = 0;
    for (int i = 0; i < 70; i++) begin
      bit w;
      w = has_room() && (n_written < 20);
      if (w) n_written++;
      cycle(0, bit'(i % 2), w ? 1 : 0, 1);
    end

    // mid-stream reset with a word on the output
    cycle(0, 0, 4, 1);
    repeat (4) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);

    // simultaneous drain and write-pointer advance
    cycle(0, 0, 1, 1);
    repeat (4) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 1);
    repeat (2) cycle(0, 0, 0, 1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      bit rst_r, rv_r, w;
      rst_r = ($urandom_range(0, 99) == 0);
      rv_r  = ($urandom_range(0, 3) != 0);
      w     = has_room() && ($urandom_range(0, 2) != 0);
      cycle(rst_r, rv_r, w ? 1 : 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
